// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester round-robin arbiter with hold limit and registered data mux
module wb_arbiter #(
  parameter int W = 8,
  parameter int MAXHOLD = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ1,
  input  logic         REQ2,
  input  logic [W-1:0] D1,
  input  logic [W-1:0] D2,
  output logic         GNT1,
  output logic         GNT2,
  output logic         S,
  output logic [W-1:0] Y,
  output logic         YV
);
  typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;
  localparam logic [3:0] HLAST = 4'(MAXHOLD - 1);
  state_t state, nxt;
  logic [3:0] hc, hc_nxt;
  logic pri, pri_nxt, s_nxt, hold_done;
  assign hold_done = hc == HLAST;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = (REQ1 && (!REQ2 || !pri)) ? OWN1 : REQ2 ? OWN2 : IDLE;
      OWN1: nxt = !REQ1 ? (REQ2 ? OWN2 : IDLE) : (REQ2 && hold_done) ? OWN2 : OWN1;
      OWN2: nxt = !REQ2 ? (REQ1 ? OWN1 : IDLE) : (REQ1 && hold_done) ? OWN1 : OWN2;
      default: nxt = IDLE;
    endcase
    hc_nxt = (nxt != state || nxt == IDLE) ? 4'd0 : hold_done ? hc : hc + 4'd1;
    pri_nxt = (state == OWN1 && nxt != OWN1) ? 1'b1 :
              (state == OWN2 && nxt != OWN2) ? 1'b0 : pri;
    s_nxt = (nxt == OWN1) ? 1'b0 : (nxt == OWN2) ? 1'b1 : S;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      GNT1  <= 1'b0;
      GNT2  <= 1'b0;
      S     <= 1'b0;
      Y     <= '0;
      YV    <= 1'b0;
      pri   <= 1'b0;
      hc    <= 4'd0;
    end else begin
      state <= nxt;
      GNT1  <= nxt == OWN1;
      GNT2  <= nxt == OWN2;
      S     <= s_nxt;
      Y     <= GNT1 ? D1 : GNT2 ? D2 : Y;
      YV    <= GNT1 | GNT2;
      pri   <= pri_nxt;
      hc    <= hc_nxt;
    end
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: W, 8, data width of each requester path and of Y.
REQ-002 Parameter: MAXHOLD, 4, max consecutive grant cycles while the other requester waits (legal 2..15).
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: REQ1  input  1  requester 1 requests the shared write path.
REQ-006 Port: REQ2  input  1  requester 2 requests the shared write path.
REQ-007 Port: D1  input  W  requester 1 data.
REQ-008 Port: D2  input  W  requester 2 data.
REQ-009 Port: GNT1  output  1  requester 1 owns the path (registered).
REQ-010 Port: GNT2  output  1  requester 2 owns the path (registered).
REQ-011 Port: S  output  1  select for the downstream 2:1 mux bank; 0 selects D1, 1 selects D2 (registered).
REQ-012 Port: Y  output  W  registered selected data.
REQ-013 Port: YV  output  1  Y holds data captured under a grant.

Function
REQ-014 States SHALL be IDLE, OWN1 and OWN2; GNT1=1 only in OWN1, GNT2=1 only in OWN2, never both.
REQ-015 S SHALL be 0 in OWN1, 1 in OWN2, and SHALL hold its last value in IDLE.
REQ-016 A 1-bit priority pointer PRI (0 favours requester 1, 1 favours requester 2) SHALL resolve simultaneous requests.
REQ-017 IDLE: REQ1 only -> OWN1; REQ2 only -> OWN2; both -> OWN1 if PRI=0 else OWN2; neither -> stay IDLE.
REQ-018 Grant latency: request sampled at edge k SHALL show GNT at edge k, i.e. visible in the cycle after the edge.
REQ-019 OWNn with REQn deasserted: if the other requester is requesting, go directly to the other OWN state on the same edge (no IDLE bubble); else go to IDLE.
REQ-020 OWNn with REQn asserted: stay; if the hold counter HC equals MAXHOLD-1 and the other requester is requesting, switch to the other OWN state.
REQ-021 HC SHALL reset to 0 on every entry to an OWN state, increment each cycle in the same OWN state, and saturate at MAXHOLD-1.
REQ-022 PRI SHALL be set to favour the other requester on every exit from an OWN state (release or forced switch).
REQ-023 Y SHALL load D1 on each edge at which GNT1=1 and D2 on each edge at which GNT2=1; otherwise Y holds.
REQ-024 YV SHALL register (GNT1|GNT2), so YV=1 exactly when Y was loaded at the previous edge.
REQ-025 Requests are level-sensitive; a requester dropping REQ while not granted SHALL leave no residual state.
REQ-026 Lone requester SHALL keep ownership indefinitely; HC saturation alone SHALL not cause release.

Reset
REQ-027 RST=1 at an edge SHALL force state IDLE, GNT1=0, GNT2=0, S=0, Y=0, YV=0, PRI=0, HC=0, regardless of current state or requests.
REQ-028 RST asserted mid-grant SHALL drop the grant at that edge; with RST low, arbitration resumes from IDLE on the next edge.

Verification
REQ-029 Reset then REQ1=1, D1=8'hA5 for 3 cycles -> GNT1=1, S=0 from cycle 1; Y=8'hA5, YV=1 from cycle 2; REQ1=0 -> IDLE, GNT1=0 next edge.
REQ-030 After reset, REQ1=REQ2=1 held, MAXHOLD=4 -> GNT1 for 4 cycles, then GNT2 for 4 cycles, alternating; S toggles 0/1 accordingly, never both grants.
REQ-031 OWN1 with REQ2=1; drop REQ1 -> GNT2=1, S=1 on the very next edge, no IDLE cycle; Y=D2 (e.g. 8'h3C) one edge later.
REQ-032 REQ2 alone for 10 cycles -> GNT2 continuous, no release at HC saturation; then REQ1 rises -> switch to OWN1 on next edge (HC already at MAXHOLD-1).
REQ-033 Assert RST during OWN2 with both requesting -> all outputs 0, S=0 at that edge; after RST drops both requesting -> OWN1 granted first (PRI=0).
REQ-034 Release OWN1 to IDLE, then REQ1=REQ2=1 simultaneously -> OWN2 granted (PRI favours requester 2); S held at 0 throughout IDLE.
